// File: rtl/hamming_enc_tx.sv
// Hamming(7,4) encoder with framed serial transmitter (start, 7 codeword bits LSB-first, stop).
// Optional build macro ERR_INJ_EN adds single-bit error injection for exercising the receiver.
//   state | meaning
//   IDLE  | waiting for a nibble, d_ready high
//   START | start bit (~IDLE_LEVEL) on tx
//   DATA  | codeword bits 1..7 on tx, r_idx selects the bit
//   STOP  | stop bit (IDLE_LEVEL) on tx
module hamming_enc_tx #(
   parameter int   BIT_CYCLES = 4,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_d_in,
   input  logic       i_d_valid,
`ifdef ERR_INJ_EN
   input  logic       i_err_en,
   input  logic [2:0] i_err_pos,
`endif
   output logic       o_d_ready,
   output logic [7:0] o_p_out,
   output logic       o_p_valid,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam int            CW     = $clog2(BIT_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic [7:0]    r_p_out, w_p_out_nxt;
   logic          r_p_valid, w_p_valid_nxt;
   logic          r_tx, w_tx_nxt;
   logic          r_done, w_done_nxt;
   logic [7:0]    w_code;
   logic [7:0]    w_cw;
   logic          w_tc;

   // {d4,d3,d2,p4,d1,p2,p1,0}
   assign w_code = {i_d_in[3], i_d_in[2], i_d_in[1],
                    i_d_in[1] ^ i_d_in[2] ^ i_d_in[3],
                    i_d_in[0],
                    i_d_in[0] ^ i_d_in[2] ^ i_d_in[3],
                    i_d_in[0] ^ i_d_in[1] ^ i_d_in[3],
                    1'b0};

`ifdef ERR_INJ_EN
   assign w_cw = (i_err_en && (i_err_pos != 3'd0)) ? (w_code ^ (8'd1 << i_err_pos)) : w_code;
`else
   assign w_cw = w_code;
`endif

   assign w_tc = (r_cnt == '0);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_p_out_nxt   = r_p_out;
      w_p_valid_nxt = r_p_valid;
      w_done_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_d_valid) begin
               w_p_out_nxt   = w_cw;
               w_p_valid_nxt = 1'b1;
               w_cnt_nxt     = RELOAD;
               w_state_nxt   = START;
            end
         end
         START: begin
            if (w_tc) begin
               w_cnt_nxt   = RELOAD;
               w_idx_nxt   = 3'd1;
               w_state_nxt = DATA;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         DATA: begin
            if (w_tc) begin
               w_cnt_nxt = RELOAD;
               if (r_idx == 3'd7) w_state_nxt = STOP;
               else               w_idx_nxt   = r_idx + 3'd1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         STOP: begin
            if (w_tc) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // tx is computed from the next state so the line is a clean register output
   always_comb begin
      w_tx_nxt = IDLE_LEVEL;
      case (w_state_nxt)
         START:   w_tx_nxt = ~IDLE_LEVEL;
         DATA:    w_tx_nxt = w_p_out_nxt[w_idx_nxt];
         default: w_tx_nxt = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= 3'd0;
         r_p_out   <= 8'd0;
         r_p_valid <= 1'b0;
         r_tx      <= IDLE_LEVEL;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_p_out   <= w_p_out_nxt;
         r_p_valid <= w_p_valid_nxt;
         r_tx      <= w_tx_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign o_d_ready = (r_state == IDLE);
   assign o_busy    = (r_state != IDLE);
   assign o_p_out   = r_p_out;
   assign o_p_valid = r_p_valid;
   assign o_tx      = r_tx;
   assign o_done    = r_done;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Directed bench for hamming_enc_tx: one instance at BIT_CYCLES=4, one at BIT_CYCLES=1.
// Error-injection scenario is compiled in when ERR_INJ_EN is defined.
module tb_hamming_enc_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d_in = 4'd0, d_in1 = 4'd0;
   logic       d_valid = 1'b0, d_valid1 = 1'b0;
   logic       d_ready, d_ready1;
   logic [7:0] p_out, p_out1;
   logic       p_valid, p_valid1, tx, tx1, busy, busy1, done, done1;
`ifdef ERR_INJ_EN
   logic       err_en = 1'b0, err_en1 = 1'b0;
   logic [2:0] err_pos = 3'd0, err_pos1 = 3'd0;
`endif

   int errors = 0;
   int checks = 0;

   // tx bit per bit-time (start, codeword bits 1..7, stop)
   logic exp_a4[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic exp_3c[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic exp_66[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [3:0] enc_d[5] = '{4'hA, 4'hF, 4'h0, 4'h3, 4'hC};
   logic [7:0] enc_p[5] = '{8'hA4, 8'hFE, 8'h00, 8'h3C, 8'hC2};

   always #5 clk = ~clk;

   hamming_enc_tx #(.BIT_CYCLES(4), .IDLE_LEVEL(1'b1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_d_in(d_in), .i_d_valid(d_valid),
`ifdef ERR_INJ_EN
      .i_err_en(err_en), .i_err_pos(err_pos),
`endif
      .o_d_ready(d_ready), .o_p_out(p_out), .o_p_valid(p_valid),
      .o_tx(tx), .o_busy(busy), .o_done(done)
   );

   hamming_enc_tx #(.BIT_CYCLES(1), .IDLE_LEVEL(1'b1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_d_in(d_in1), .i_d_valid(d_valid1),
`ifdef ERR_INJ_EN
      .i_err_en(err_en1), .i_err_pos(err_pos1),
`endif
      .o_d_ready(d_ready1), .o_p_out(p_out1), .o_p_valid(p_valid1),
      .o_tx(tx1), .o_busy(busy1), .o_done(done1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the sample point just after the accepting edge.
   task automatic send(input logic [3:0] d);
      d_in    = d;
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL rst_tx got=%b exp=1", tx); end
      checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL rst_p_out got=%h exp=00", p_out); end
      checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL rst_p_valid got=%b exp=0", p_valid); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      rst = 1'b0;
      tick();
      checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL rst_d_ready got=%b exp=1", d_ready); end
   endtask

   task automatic test_encode();
      for (int i = 0; i < 5; i++) begin
         send(enc_d[i]);
         checks++; if (p_out !== enc_p[i]) begin errors++; $display("FAIL enc_p_out d=%h got=%h exp=%h", enc_d[i], p_out, enc_p[i]); end
         checks++; if (p_valid !== 1'b1 || busy !== 1'b1 || d_ready !== 1'b0) begin
            errors++; $display("FAIL enc_flags d=%h p_valid=%b busy=%b d_ready=%b exp 1/1/0", enc_d[i], p_valid, busy, d_ready);
         end
         wait_done();
         checks++; if (p_out !== enc_p[i] || p_valid !== 1'b1) begin
            errors++; $display("FAIL enc_hold d=%h got=%h/%b exp=%h/1", enc_d[i], p_out, p_valid, enc_p[i]);
         end
         tick();
      end
   endtask

   task automatic test_serial();
      send(4'hA);
      // k counts edges after the accepting edge; done lands on the 37th edge counting acceptance as the 1st
      for (int k = 0; k < 36; k++) begin
         checks++; if (tx !== exp_a4[k/4] || done !== 1'b0) begin
            errors++; $display("FAIL serial k=%0d tx=%b done=%b exp tx=%b done=0", k, tx, done, exp_a4[k/4]);
         end
         tick();
      end
      checks++; if (done !== 1'b1 || d_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL serial_end done=%b d_ready=%b tx=%b busy=%b exp 1/1/1/0", done, d_ready, tx, busy);
      end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", done); end
   endtask

   task automatic test_ignore();
      send(4'h5);
      d_in    = 4'hF;
      d_valid = 1'b1;
      repeat (5) tick();
      d_valid = 1'b0;
      checks++; if (p_out !== 8'h5A || d_ready !== 1'b0) begin
         errors++; $display("FAIL ignore p_out=%h d_ready=%b exp 5a/0", p_out, d_ready);
      end
      wait_done();
      checks++; if (p_out !== 8'h5A) begin errors++; $display("FAIL ignore_end p_out=%h exp=5a", p_out); end
      tick();
   endtask

   task automatic test_back_to_back();
      d_in    = 4'h3;
      d_valid = 1'b1;
      tick();
      d_in = 4'hC;
      for (int k = 0; k < 36; k++) begin
         checks++; if (d_ready !== 1'b0 || tx !== exp_3c[k/4]) begin
            errors++; $display("FAIL b2b k=%0d d_ready=%b tx=%b exp 0/%b", k, d_ready, tx, exp_3c[k/4]);
         end
         tick();
      end
      checks++; if (done !== 1'b1 || d_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_done done=%b d_ready=%b exp 1/1", done, d_ready);
      end
      tick();
      d_valid = 1'b0;
      checks++; if (p_out !== 8'hC2 || tx !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL b2b_second p_out=%h tx=%b busy=%b exp c2/0/1", p_out, tx, busy);
      end
      wait_done();
      tick();
   endtask

   task automatic test_bc1();
      d_in1    = 4'b0110;
      d_valid1 = 1'b1;
      tick();
      d_valid1 = 1'b0;
      checks++; if (p_out1 !== 8'h66) begin errors++; $display("FAIL bc1_p_out got=%h exp=66", p_out1); end
      for (int k = 0; k < 9; k++) begin
         checks++; if (tx1 !== exp_66[k] || done1 !== 1'b0) begin
            errors++; $display("FAIL bc1_serial k=%0d tx=%b done=%b exp tx=%b done=0", k, tx1, done1, exp_66[k]);
         end
         tick();
      end
      checks++; if (done1 !== 1'b1 || d_ready1 !== 1'b1) begin
         errors++; $display("FAIL bc1_done done=%b d_ready=%b exp 1/1", done1, d_ready1);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      send(4'hA);
      repeat (6) tick();
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_pre tx=%b busy=%b exp 0/1", tx, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || p_valid !== 1'b0 || p_out !== 8'h00) begin
         errors++; $display("FAIL mid_rst tx=%b busy=%b p_valid=%b p_out=%h exp 1/0/0/00", tx, busy, p_valid, p_out);
      end
      repeat (3) begin
         tick();
         if (done === 1'b1) seen++;
      end
      rst = 1'b0;
      tick();
      checks++; if (d_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_release d_ready=%b busy=%b exp 1/0", d_ready, busy);
      end
      repeat (40) begin
         if (done === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_done pulses=%0d exp=0", seen); end
   endtask

`ifdef ERR_INJ_EN
   task automatic test_err_inj();
      err_en  = 1'b1;
      err_pos = 3'd5;
      send(4'hA);
      err_en  = 1'b0;
      err_pos = 3'd0;
      checks++; if (p_out !== 8'h84) begin errors++; $display("FAIL err_p_out got=%h exp=84", p_out); end
      repeat (20) tick();
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL err_tx_bit5 got=%b exp=0", tx); end
      wait_done();
      tick();
      err_en  = 1'b1;
      err_pos = 3'd0;
      send(4'hA);
      err_en = 1'b0;
      checks++; if (p_out !== 8'hA4) begin errors++; $display("FAIL err_pos0 got=%h exp=a4", p_out); end
      wait_done();
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_encode();
      test_serial();
      test_ignore();
      test_back_to_back();
      test_bc1();
`ifdef ERR_INJ_EN
      test_err_inj();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
